// File: rtl/miner_pkg.sv
// Shared types and default sizes for the miner datapath blocks.
package miner_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 8;
    localparam int NONCE_W   = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_SHA,
        COMPARE,
        REPORT
    } hv_state_t;

endpackage

// File: rtl/hash_validator_if.sv
// Handshake bundle between the mining controller, SHA core and hash_validator.
interface hash_validator_if #(
    parameter int NONCE_W = miner_pkg::NONCE_W,
    parameter int HASH_W  = miner_pkg::WORD_W * miner_pkg::NUM_WORDS
);
    logic              newTarget;
    logic [HASH_W-1:0] target_in;
    logic              newMsg;
    logic              beginSHA;
    logic              increment;
    logic              sha_start;
    logic              sha_done;
    logic [HASH_W-1:0] digest;
    logic              complete;
    logic              valid;
    logic              finishedValidating;
    logic              overflow;
    logic [NONCE_W-1:0] nonce;

    modport master (
        output newTarget, target_in, newMsg, beginSHA, increment, sha_done, digest,
        input  sha_start, complete, valid, finishedValidating, overflow, nonce
    );

    modport slave (
        input  newTarget, target_in, newMsg, beginSHA, increment, sha_done, digest,
        output sha_start, complete, valid, finishedValidating, overflow, nonce
    );
endinterface

// File: rtl/nonce_counter.sv
// Nonce register: clear-to-zero, saturating increment, all-ones overflow flag.
module nonce_counter #(
    parameter int NONCE_W = miner_pkg::NONCE_W
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               increment,
    output logic [NONCE_W-1:0] nonce,
    output logic               overflow
);
    logic [NONCE_W-1:0] count;

    // Clear has priority; once saturated the count holds at all ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (increment && !(&count)) begin
            count <= count + NONCE_W'(1);
        end
    end

    assign nonce    = count;
    assign overflow = &count;
endmodule

// File: rtl/hash_validator.sv
// Launches the SHA core, captures its digest and compares it MSW-first against the target.
module hash_validator #(
    parameter int WORD_W    = miner_pkg::WORD_W,
    parameter int NUM_WORDS = miner_pkg::NUM_WORDS,
    parameter int NONCE_W   = miner_pkg::NONCE_W
) (
    input logic             clk,
    input logic             n_rst,
    hash_validator_if.slave bus
);
    import miner_pkg::*;

    localparam int HASH_W = WORD_W * NUM_WORDS;
    localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    hv_state_t          state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [HASH_W-1:0]  target_q, digest_q;
    logic [WORD_W-1:0]  dig_word, tgt_word;
    logic               start_nxt, complete_nxt, valid_nxt, fin_nxt;
    logic               sha_start_q, complete_q, valid_q, fin_q;

    // Word i counts from the most significant end of the big-endian vector.
    function automatic logic [WORD_W-1:0] word_sel(input logic [HASH_W-1:0] vec,
                                                   input logic [IDX_W-1:0]  i);
        int sh;
        sh = (NUM_WORDS - 1 - int'(i)) * WORD_W;
        return WORD_W'(vec >> sh);
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            idx         <= '0;
            sha_start_q <= 1'b0;
            complete_q  <= 1'b0;
            valid_q     <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            sha_start_q <= start_nxt;
            complete_q  <= complete_nxt;
            valid_q     <= valid_nxt;
            fin_q       <= fin_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        start_nxt    = 1'b0;
        complete_nxt = 1'b0;
        valid_nxt    = 1'b0;
        fin_nxt      = 1'b0;
        dig_word     = word_sel(digest_q, idx);
        tgt_word     = word_sel(target_q, idx);
        case (state)
            IDLE: begin
                if (bus.beginSHA) begin
                    state_nxt = START;
                    start_nxt = 1'b1;
                end
            end
            START: state_nxt = WAIT_SHA;
            WAIT_SHA: begin
                if (bus.sha_done) begin
                    state_nxt    = COMPARE;
                    idx_nxt      = '0;
                    complete_nxt = 1'b1;
                end
            end
            COMPARE: begin
                // A digest equal to the target in every word is not a win.
                if (dig_word < tgt_word) begin
                    state_nxt = REPORT;
                    valid_nxt = 1'b1;
                end else if (dig_word > tgt_word || idx == LAST_IDX) begin
                    state_nxt = REPORT;
                    fin_nxt   = 1'b1;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Target only changes between attempts; the digest only on a live done strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            target_q <= '0;
            digest_q <= '0;
        end else begin
            if (state == IDLE && bus.newTarget) target_q <= bus.target_in;
            if (state == WAIT_SHA && bus.sha_done) digest_q <= bus.digest;
        end
    end

    nonce_counter #(.NONCE_W(NONCE_W)) u_nonce (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (bus.newMsg),
        .increment (bus.increment),
        .nonce     (bus.nonce),
        .overflow  (bus.overflow)
    );

    assign bus.sha_start          = sha_start_q;
    assign bus.complete           = complete_q;
    assign bus.valid              = valid_q;
    assign bus.finishedValidating = fin_q;
endmodule

// File: tb/tb_hash_validator.sv
// Directed bench for hash_validator with a result scoreboard.
module tb_hash_validator;
    import miner_pkg::*;

    typedef struct {
        bit is_valid;
        int k;
    } exp_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    hash_validator_if #(.NONCE_W(32), .HASH_W(256)) bus ();

    hash_validator dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic start_attempt(input string tag, input logic [255:0] tgt);
        bus.newTarget = 1'b1;
        bus.target_in = tgt;
        tick();
        bus.newTarget = 1'b0;
        bus.beginSHA  = 1'b1;
        tick();
        bus.beginSHA  = 1'b0;
        check({tag, " sha_start"}, bus.sha_start, 1'b1);
        tick();
        check({tag, " sha_start_one_cycle"}, bus.sha_start, 1'b0);
    endtask

    // Drives sha_done, then pops the scoreboard entry when a result pulse appears.
    task automatic finish_attempt(input string tag, input logic [255:0] dig,
                                  input bit stray, input logic [255:0] stray_tgt);
        exp_t e;
        bit   seen;
        seen         = 1'b0;
        bus.sha_done = 1'b1;
        bus.digest   = dig;
        tick();
        bus.sha_done = 1'b0;
        check({tag, " complete"}, bus.complete, 1'b1);
        if (stray) begin
            bus.newTarget = 1'b1;
            bus.target_in = stray_tgt;
        end
        for (int cyc = 2; cyc <= 12; cyc++) begin
            tick();
            bus.newTarget = 1'b0;
            if (bus.valid || bus.finishedValidating) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                check({tag, " valid"}, bus.valid, e.is_valid);
                check({tag, " finishedValidating"}, bus.finishedValidating, !e.is_valid);
                check({tag, " latency"}, cyc, e.k + 1);
                check({tag, " complete_dropped"}, bus.complete, 1'b0);
                break;
            end
        end
        check({tag, " result_seen"}, seen, 1'b1);
        tick();
        check({tag, " back_idle"}, dut.state, IDLE);
        check({tag, " pulses_dropped"}, {bus.valid, bus.finishedValidating}, 2'b00);
    endtask

    initial begin
        logic [255:0] t;
        logic [255:0] d;
        bus.newTarget = 1'b0;
        bus.target_in = '0;
        bus.newMsg    = 1'b0;
        bus.beginSHA  = 1'b0;
        bus.increment = 1'b0;
        bus.sha_done  = 1'b0;
        bus.digest    = '0;
        repeat (3) tick();
        n_rst = 1'b1;
        tick();

        check("reset outputs",
              {bus.sha_start, bus.complete, bus.valid, bus.finishedValidating, bus.overflow}, 5'b0);
        check("reset nonce", bus.nonce, 32'd0);
        check("reset state", dut.state, IDLE);

        // Early win on the most significant word.
        t = {32'h0000_0001, {224{1'b1}}};
        d = {32'h0000_0000, {224{1'b1}}};
        exp_q.push_back('{1'b1, 1});
        start_attempt("early", t);
        finish_attempt("early", d, 1'b0, '0);

        // Exact match is not a win and needs all eight words.
        t = {8{32'hABCD_0123}};
        exp_q.push_back('{1'b0, 8});
        start_attempt("equal", t);
        finish_attempt("equal", t, 1'b0, '0);

        // Only the least significant word differs.
        t = {{7{32'h1234_5678}}, 32'h0000_0006};
        d = {{7{32'h1234_5678}}, 32'h0000_0005};
        exp_q.push_back('{1'b1, 8});
        start_attempt("late", t);
        finish_attempt("late", d, 1'b0, '0);

        // Digest greater on the third word.
        t = {32'h1, 32'h2, 32'h3, 160'h0};
        d = {32'h1, 32'h2, 32'h4, 160'h0};
        exp_q.push_back('{1'b0, 3});
        start_attempt("greater", t);
        finish_attempt("greater", d, 1'b0, '0);

        // Nonce counting, priority of newMsg and saturation.
        bus.newMsg = 1'b1;
        tick();
        bus.newMsg = 1'b0;
        check("nonce cleared", bus.nonce, 32'd0);
        bus.increment = 1'b1;
        repeat (3) tick();
        bus.increment = 1'b0;
        check("nonce three", bus.nonce, 32'd3);
        check("overflow low", bus.overflow, 1'b0);
        bus.newMsg    = 1'b1;
        bus.increment = 1'b1;
        tick();
        bus.newMsg    = 1'b0;
        bus.increment = 1'b0;
        check("newMsg wins", bus.nonce, 32'd0);
        force dut.u_nonce.count = 32'hFFFF_FFFE;
        tick();
        release dut.u_nonce.count;
        tick();
        check("nonce preset", bus.nonce, 32'hFFFF_FFFE);
        check("overflow before", bus.overflow, 1'b0);
        bus.increment = 1'b1;
        tick();
        check("nonce max", bus.nonce, 32'hFFFF_FFFF);
        check("overflow set", bus.overflow, 1'b1);
        tick();
        bus.increment = 1'b0;
        check("nonce no wrap", bus.nonce, 32'hFFFF_FFFF);
        check("overflow held", bus.overflow, 1'b1);
        bus.newMsg = 1'b1;
        tick();
        bus.newMsg = 1'b0;
        check("nonce reload", bus.nonce, 32'd0);
        check("overflow cleared", bus.overflow, 1'b0);

        // Ignored beginSHA in WAIT_SHA and newTarget in COMPARE.
        t = {32'h5, 32'h8, 192'h0};
        d = {32'h5, 32'h7, 192'h0};
        exp_q.push_back('{1'b1, 2});
        start_attempt("ignored", t);
        bus.beginSHA = 1'b1;
        tick();
        bus.beginSHA = 1'b0;
        check("ignored no_restart", bus.sha_start, 1'b0);
        check("ignored still_waiting", dut.state, WAIT_SHA);
        tick();
        check("ignored no_late_start", bus.sha_start, 1'b0);
        finish_attempt("ignored", d, 1'b1, {32'h5, 32'h6, 192'h0});
        check("ignored target_kept", dut.target_q, t);

        // Stray sha_done while idle.
        bus.sha_done = 1'b1;
        tick();
        bus.sha_done = 1'b0;
        check("stray no_complete", bus.complete, 1'b0);
        check("stray idle", dut.state, IDLE);
        tick();
        check("stray no_complete_late", bus.complete, 1'b0);

        // Reset in the middle of a long comparison.
        bus.increment = 1'b1;
        tick();
        bus.increment = 1'b0;
        check("pre_reset nonce", bus.nonce, 32'd1);
        t = {8{32'h0F0F_F0F0}};
        start_attempt("midrst", t);
        bus.sha_done = 1'b1;
        bus.digest   = t;
        tick();
        bus.sha_done = 1'b0;
        check("midrst complete", bus.complete, 1'b1);
        tick();
        tick();
        n_rst = 1'b0;
        #1;
        check("midrst outputs",
              {bus.sha_start, bus.complete, bus.valid, bus.finishedValidating, bus.overflow}, 5'b0);
        check("midrst nonce", bus.nonce, 32'd0);
        check("midrst state", dut.state, IDLE);
        tick();
        n_rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_reset quiet",
                  {bus.sha_start, bus.complete, bus.valid, bus.finishedValidating}, 4'b0);
        end
        check("post_reset state", dut.state, IDLE);
        check("post_reset target", dut.target_q, 256'd0);
        check("post_reset digest", dut.digest_q, 256'd0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
